hack_pc_branch: RTL and testbench
=================================

// Module: hack_pc_branch
// PURPOSE
//   Program counter and branch-resolution stage of the Hack CPU. Consumes the
//   ALU status flags (zr from the zero checker, ng from the ALU MSB) plus the
//   C-instruction jump bits, and decides whether PC loads the A-register
//   target or increments. Detects the Hack "@END; 0;JMP" self-loop idiom and
//   parks in HALTED. Counts taken branches for debug.
// PARAMETERS
//   ADDR_W        15   PC / ROM address width in bits
//   RESET_VECTOR  0    PC value after async or sync reset
// PORTS
//   clk         in   1       system clock, rising edge
//   rst_n       in   1       asynchronous, active-low reset
//   soft_rst    in   1       synchronous Hack "reset" button, active-high
//   en          in   1       advance enable; 0 = stall, all state holds
//   instr_valid in   1       current instruction is valid this cycle
//   is_c_instr  in   1       1 = C-instruction, 0 = A-instruction
//   jump_bits   in   3       {j1,j2,j3} from instruction[2:0]
//   zr          in   1       ALU result == 0 (zero checker output)
//   ng          in   1       ALU result < 0
//   a_reg       in   ADDR_W  jump target (A register low bits)
//   pc          out  ADDR_W  current instruction address
//   taken       out  1       registered 1-cycle pulse, branch taken
//   halted      out  1       1 while in HALTED state
//   jump_cnt    out  16      taken-branch count, saturating
// BEHAVIOUR
//   Reset (rst_n=0, async): pc=RESET_VECTOR, taken=0, halted=0, jump_cnt=0,
//     state=RUN. Release takes effect on the first rising clk after deassert.
//   Condition: cond = (j1&ng) | (j2&zr) | (j3&~zr&~ng); flags used as given,
//     no check for illegal zr&ng=1. jump_bits=111 -> always; 000 -> never.
//   jump = instr_valid & is_c_instr & cond. A-instr / invalid never jump.
//   States: RUN, HALTED. Per rising clk, priority highest first:
//     1. soft_rst=1: as async reset (pc, counters, state), regardless of en.
//     2. en=0: pc, state, jump_cnt hold; taken <= 0.
//     3. HALTED: pc holds, halted=1, taken <= 0; exit only via 1 or rst_n.
//     4. RUN & jump: pc <= a_reg; taken <= 1; jump_cnt += 1 (sat 16'hFFFF);
//        if a_reg == pc, state <= HALTED, halted=1 from next cycle.
//     5. RUN & ~jump: pc <= pc + 1, wraps 2^ADDR_W-1 -> 0; taken <= 0.
//   Latency: decision is same-cycle combinational from inputs; pc, taken,
//     halted update 1 clk later. No combinational path from inputs to outputs.
//   Self-loop halt includes the taken cycle: taken=1 and halted=1 are both
//     visible in the cycle after the halting jump.
//   jump_cnt sticks at 16'hFFFF; further jumps still redirect pc.
// TESTING
//   1. rst_n=0 mid-run (pc=0x0123) -> pc=0, taken=0, halted=0, cnt=0
//      immediately, without waiting for clk.
//   2. en=1, no jumps, 5 clks from 0 -> pc=5; preset pc=0x7FFF, 1 clk -> 0.
//   3. Jump table: all 8 jump_bits x {zr,ng}={00,01,10}, a_reg=0x0040 ->
//      pc=0x0040 + taken=1 exactly when cond, else pc+1.
//   4. is_c_instr=0, jump_bits=111 -> pc+1, taken=0, cnt unchanged.
//   5. pc=0x0010, a_reg=0x0010, 0;JMP -> taken=1, halted=1; 4 more clks
//      pc=0x0010, taken=0; soft_rst -> pc=0, halted=0.
//   6. en=0 with a valid jump -> pc unchanged; 0x10000 jumps -> cnt=FFFF.

Source files
------------

// File: rtl/hack_pc_branch.sv
// rtl/hack_pc_branch.sv - Hack CPU program counter with branch resolution,
// self-loop halt detection and a saturating taken-branch counter.
module hack_pc_branch #(
   parameter int ADDR_W       = 15,
   parameter int RESET_VECTOR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              soft_rst,
   input  logic              en,
   input  logic              instr_valid,
   input  logic              is_c_instr,
   input  logic [2:0]        jump_bits,
   input  logic              zr,
   input  logic              ng,
   input  logic [ADDR_W-1:0] a_reg,
   output logic [ADDR_W-1:0] pc,
   output logic              taken,
   output logic              halted,
   output logic [15:0]       jump_cnt
);

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VECTOR);

   state_t state;
   logic   cond;
   logic   jump;
   logic   self_loop;

   // Flags are taken at face value; the illegal zr&ng combination is not filtered.
   assign cond      = (jump_bits[2] & ng) | (jump_bits[1] & zr) | (jump_bits[0] & ~zr & ~ng);
   assign jump      = instr_valid & is_c_instr & cond;
   assign self_loop = (a_reg == pc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         pc       <= RST_PC;
         taken    <= 1'b0;
         halted   <= 1'b0;
         jump_cnt <= 16'd0;
      end else if (soft_rst) begin
         state    <= RUN;
         pc       <= RST_PC;
         taken    <= 1'b0;
         halted   <= 1'b0;
         jump_cnt <= 16'd0;
      end else if (!en) begin
         taken <= 1'b0;
      end else begin
         case (state)
            HALTED: begin
               taken  <= 1'b0;
               halted <= 1'b1;
            end
            default: begin
               if (jump) begin
                  pc    <= a_reg;
                  taken <= 1'b1;
                  if (jump_cnt != 16'hFFFF)
                     jump_cnt <= jump_cnt + 16'd1;
                  // "@END; 0;JMP": jumping onto ourselves parks the core.
                  if (self_loop) begin
                     state  <= HALTED;
                     halted <= 1'b1;
                  end
               end else begin
                  pc    <= pc + {{(ADDR_W-1){1'b0}}, 1'b1};
                  taken <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hack_pc_branch.sv
// tb/tb_hack_pc_branch.sv - randomized scoreboard bench for hack_pc_branch.
module tb_hack_pc_branch;

   localparam int ADDR_W = 15;
   localparam int PC_MOD = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              soft_rst = 1'b0;
   logic              en = 1'b0;
   logic              instr_valid = 1'b0;
   logic              is_c_instr = 1'b0;
   logic [2:0]        jump_bits = 3'b000;
   logic              zr = 1'b0;
   logic              ng = 1'b0;
   logic [ADDR_W-1:0] a_reg = '0;
   logic [ADDR_W-1:0] pc;
   logic              taken;
   logic              halted;
   logic [15:0]       jump_cnt;

   hack_pc_branch #(.ADDR_W(ADDR_W), .RESET_VECTOR(0)) dut (
      .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst), .en(en),
      .instr_valid(instr_valid), .is_c_instr(is_c_instr), .jump_bits(jump_bits),
      .zr(zr), .ng(ng), .a_reg(a_reg),
      .pc(pc), .taken(taken), .halted(halted), .jump_cnt(jump_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int pc;
      bit taken;
      bit halted;
      int cnt;
      string tag;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Reference model state: architectural view of the PC stage.
   int m_pc = 0;
   bit m_taken = 0;
   bit m_halted = 0;
   int m_cnt = 0;

   task automatic check(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic model_reset();
      m_pc = 0; m_taken = 0; m_halted = 0; m_cnt = 0;
   endtask

   task automatic step(input bit srst, input bit e, input bit v, input bit c,
                       input bit [2:0] jb, input bit z, input bit n, input int a,
                       input string tag);
      bit   cnd;
      bit   jmp;
      exp_t x;
      @(negedge clk);
      soft_rst = srst; en = e; instr_valid = v; is_c_instr = c;
      jump_bits = jb; zr = z; ng = n; a_reg = ADDR_W'(a);
      cnd = (jb[2] && n) || (jb[1] && z) || (jb[0] && !z && !n);
      jmp = v && c && cnd;
      if (srst) model_reset();
      else if (!e || m_halted) m_taken = 0;
      else if (jmp) begin
         m_taken = 1;
         if (m_cnt < 65535) m_cnt = m_cnt + 1;
         if (a == m_pc) m_halted = 1;
         m_pc = a;
      end else begin
         m_pc = (m_pc + 1) % PC_MOD;
         m_taken = 0;
      end
      x.pc = m_pc; x.taken = m_taken; x.halted = m_halted; x.cnt = m_cnt; x.tag = tag;
      q.push_back(x);
   endtask

   task automatic nojump(input string tag);
      step(0, 1, 1, 0, 3'b000, 0, 0, 0, tag);
   endtask

   task automatic jmp_to(input int a, input string tag);
      step(0, 1, 1, 1, 3'b111, 0, 0, a, tag);
   endtask

   // Monitor: every rising edge yields one output sample to score.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            x = q.pop_front();
            check({x.tag, ".pc"}, int'(pc), x.pc);
            check({x.tag, ".taken"}, int'(taken), int'(x.taken));
            check({x.tag, ".halted"}, int'(halted), int'(x.halted));
            check({x.tag, ".cnt"}, int'(jump_cnt), x.cnt);
         end
      end
   end

   initial begin
      #(1_500_000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a;
      bit z;
      bit n;
      // Power-on reset state
      repeat (3) @(posedge clk);
      #1;
      check("por.pc", int'(pc), 0);
      check("por.taken", int'(taken), 0);
      check("por.halted", int'(halted), 0);
      check("por.cnt", int'(jump_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Free-running increment
      for (int i = 0; i < 5; i++) nojump("inc");
      // Wrap from the top of the address space
      jmp_to(32'h7FFF, "to_top");
      nojump("wrap");

      // Jump table: every jump field against legal flag combinations
      for (int jb = 0; jb < 8; jb++) begin
         for (int f = 0; f < 3; f++) begin
            step(1, 1, 0, 0, 3'b000, 0, 0, 0, "tbl_srst");
            step(0, 1, 1, 1, 3'(jb), f == 2, f == 1, 32'h0040, $sformatf("tbl%0d_%0d", jb, f));
         end
      end

      // A-instruction and invalid instruction never jump
      step(0, 1, 1, 0, 3'b111, 0, 0, 32'h0040, "a_instr");
      step(0, 1, 0, 1, 3'b111, 0, 0, 32'h0040, "invalid");

      // Stall with a valid jump pending
      step(0, 0, 1, 1, 3'b111, 0, 0, 32'h0200, "stall");
      step(0, 0, 1, 1, 3'b111, 0, 0, 32'h0200, "stall2");

      // Self-loop halt, park, then soft reset out
      step(1, 1, 0, 0, 3'b000, 0, 0, 0, "h_srst");
      jmp_to(32'h0010, "h_goto");
      jmp_to(32'h0010, "h_halt");
      for (int i = 0; i < 4; i++)
         step(0, 1, 1, 1, 3'b111, 0, 0, 32'h0300, "h_park");
      step(1, 0, 0, 0, 3'b000, 0, 0, 0, "h_exit");

      // Async reset mid-run at pc=0x0123
      jmp_to(32'h0123, "pre_rst");
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst.pc", int'(pc), 0);
      check("arst.taken", int'(taken), 0);
      check("arst.halted", int'(halted), 0);
      check("arst.cnt", int'(jump_cnt), 1 - 1);
      model_reset();
      rst_n = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         z = ($urandom_range(3) == 0);
         n = !z && ($urandom_range(2) == 0);
         a = ($urandom_range(7) == 0) ? m_pc : int'($urandom_range(PC_MOD - 1));
         step($urandom_range(31) == 0, $urandom_range(7) != 0, $urandom_range(7) != 0,
              $urandom_range(3) != 0, 3'($urandom_range(7)), z, n, a, "rand");
      end

      // Counter saturation: 0x10000 jumps plus a few beyond
      step(1, 1, 0, 0, 3'b000, 0, 0, 0, "sat_srst");
      for (int i = 0; i < 65536 + 3; i++)
         jmp_to((m_pc + 5) % PC_MOD, "sat");
      nojump("sat_after");

      repeat (2) @(posedge clk);
      #2;
      check("queue_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
